frontend_backend_fifo: RTL and testbench

- Decoupling queue on the frontend-to-backend packet interface; the receiving end of the frontend output.
- Accepts one frontend_packet_t per cycle from the ISU stage and drives backend_busy as backpressure to the frontend.
- Presents packets in program order to the backend execute stage over a valid/ready handshake.
- Discards all contents on pipeline flush (redirect).

---
 rtl/frontend_backend_fifo.sv | 148 ++++++++++++++
 tb/tb_frontend_backend_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/frontend_backend_fifo.sv
// -----------------------------------------------------------------------------
// frontend_backend_fifo
//
// Decoupling queue between the frontend ISU stage and the backend execute
// stage. Accepts at most one frontend packet per cycle and returns them in
// program order over a valid/ready handshake. A pipeline flush discards every
// queued packet.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-low reset
//   flush        pipeline flush (redirect); empties the queue, wins over push/pop
//   in_packet    packet from the frontend; its leading valid bit marks a real op
//   in_stall     frontend ISU hazard stall; in_packet is being held, do not take it
//   backend_busy backpressure to the frontend; 1 when the queue is full
//   out_packet   head entry, all zeros when the queue is empty
//   out_valid    head entry is valid
//   out_ready    backend consumes the head entry this cycle
//   fifo_count   current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------

package frontend_pkg;

   // valid is the most significant field so that it leads the packed vector.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [4:0]  rd;
   } frontend_packet_t;

endpackage

module frontend_backend_fifo
   import frontend_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [$bits(frontend_packet_t)-1:0]  in_packet,
   input  logic                                 in_stall,
   output logic                                 backend_busy,
   output logic [$bits(frontend_packet_t)-1:0]  out_packet,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [$clog2(DEPTH):0]               fifo_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("frontend_backend_fifo: DEPTH must be a power of two and at least 2");
   end

   frontend_packet_t in_pkt;
   frontend_packet_t mem_q [DEPTH];

   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q,  count_d;

   logic full;
   logic push;
   logic pop;

   assign in_pkt = frontend_packet_t'(in_packet);

   // Status is derived from registered state only, so backend_busy has no
   // combinational path from out_ready or in_packet.
   assign full      = (count_q == CntW'(DEPTH));
   assign out_valid = (count_q != '0);

   // A full queue refuses a push even when a pop happens in the same cycle;
   // the frontend sees backend_busy and holds its packet for the next cycle.
   assign push = in_pkt.valid & ~in_stall & ~full & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers are PtrW bits wide and DEPTH is a power of two, so the
         // increment wraps from DEPTH-1 to 0 without extra logic.
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only slots between rd_ptr and wr_ptr are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_pkt;
      end
   end

   always_comb begin
      out_packet = '0;
      if (out_valid) begin
         out_packet = mem_q[rd_ptr_q];
      end
   end

   assign backend_busy = full;
   assign fifo_count   = count_q;

   // Simulation-only sanity checks.
   a_count_bound: assert property (@(posedge clk) disable iff (!rst)
      count_q <= CntW'(DEPTH));

   a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst)
      !(pop && count_q == '0));

   a_head_stable: assert property (@(posedge clk) disable iff (!rst)
      (out_valid && !out_ready && !flush) |=> $stable(out_packet));

endmodule

// File: tb/tb_frontend_backend_fifo.sv
module tb_frontend_backend_fifo;
   import frontend_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = $bits(frontend_packet_t);

   logic             clk;
   logic             rst;
   logic             flush;
   frontend_packet_t in_pkt;
   logic             in_stall;
   logic             backend_busy;
   frontend_packet_t out_pkt;
   logic             out_valid;
   logic             out_ready;
   logic [$clog2(DEPTH):0] fifo_count;

   int tests;
   int fails;

   // Reference contents of the queue, oldest first.
   frontend_packet_t model[$];

   frontend_backend_fifo #(
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_packet    (in_pkt),
      .in_stall     (in_stall),
      .backend_busy (backend_busy),
      .out_packet   (out_pkt),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fifo_count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        flush;
      logic        valid;
      logic [31:0] pc;
      logic        stall;
      logic        ready;
      int          exp_count;
      logic        exp_valid;
      logic        exp_busy;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic frontend_packet_t mk(logic v, logic [31:0] pc);
      frontend_packet_t p;
      p.valid   = v;
      p.pc      = pc;
      p.instr   = pc ^ 32'h1357_9bdf;
      p.rs1_val = {pc[15:0], pc[31:16]};
      p.rs2_val = ~pc;
      p.rd      = pc[6:2];
      return p;
   endfunction

   function automatic vec_t v(logic rn, logic fl, logic vl, logic [31:0] pc, logic st,
                              logic rd, int ec, logic ev, logic eb, logic [31:0] ep);
      vec_t x;
      x.rst_n = rn; x.flush = fl; x.valid = vl; x.pc = pc; x.stall = st; x.ready = rd;
      x.exp_count = ec; x.exp_valid = ev; x.exp_busy = eb; x.exp_pc = ep;
      return x;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_pkt(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: update the scoreboard from the inputs driven now, let the edge
   // happen, then compare every output against the scoreboard.
   task automatic tick();
      frontend_packet_t head;
      if (!rst || flush) begin
         model.delete();
      end else begin
         logic do_push;
         do_push = in_pkt.valid && !in_stall && (model.size() < DEPTH);
         if (model.size() != 0 && out_ready) begin
            chk_pkt("sb_pop", out_pkt, model[0]);
            void'(model.pop_front());
         end
         if (do_push) model.push_back(in_pkt);
      end
      @(posedge clk);
      #1;
      head = (model.size() != 0) ? model[0] : '0;
      chk("fifo_count", 64'(fifo_count), 64'(model.size()));
      chk("out_valid", 64'(out_valid), 64'(model.size() != 0));
      chk("backend_busy", 64'(backend_busy), 64'(model.size() == DEPTH));
      chk_pkt("out_packet", out_pkt, head);
   endtask

   task automatic drive(logic rn, logic fl, logic vl, logic [31:0] pc, logic st, logic rd);
      rst       = rn;
      flush     = fl;
      in_pkt    = mk(vl, pc);
      in_stall  = st;
      out_ready = rd;
   endtask

   initial begin
      logic [31:0] prev_pc;
      tests = 0;
      fails = 0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

      //            rst  fl  vl  pc            st  rd  cnt val bsy head_pc
      // Reset, then three pushes with the backend stalled.
      vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(v(1, 0, 1, 32'h8000_0000, 0, 0, 1, 1, 0, 32'h8000_0000));
      vecs.push_back(v(1, 0, 1, 32'h8000_0004, 0, 0, 2, 1, 0, 32'h8000_0000));
      vecs.push_back(v(1, 0, 1, 32'h8000_0008, 0, 0, 3, 1, 0, 32'h8000_0000));
      // Empty via flush, fill to DEPTH, 5th refused, pop from full, 5th accepted.
      vecs.push_back(v(1, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(v(1, 0, 1, 32'h1000,     0, 0, 1, 1, 0, 32'h1000));
      vecs.push_back(v(1, 0, 1, 32'h1004,     0, 0, 2, 1, 0, 32'h1000));
      vecs.push_back(v(1, 0, 1, 32'h1008,     0, 0, 3, 1, 0, 32'h1000));
      vecs.push_back(v(1, 0, 1, 32'h100c,     0, 0, 4, 1, 1, 32'h1000));
      vecs.push_back(v(1, 0, 1, 32'h1010,     0, 0, 4, 1, 1, 32'h1000));
      vecs.push_back(v(1, 0, 1, 32'h1010,     0, 1, 3, 1, 0, 32'h1004));
      vecs.push_back(v(1, 0, 1, 32'h1010,     0, 0, 4, 1, 1, 32'h1004));
      vecs.push_back(v(1, 0, 0, 32'h0,        0, 1, 3, 1, 0, 32'h1008));
      vecs.push_back(v(1, 0, 0, 32'h0,        0, 1, 2, 1, 0, 32'h100c));
      vecs.push_back(v(1, 0, 0, 32'h0,        0, 1, 1, 1, 0, 32'h1010));
      vecs.push_back(v(1, 0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0));
      // Held packet under in_stall is taken exactly once; valid=0 never enqueued.
      vecs.push_back(v(1, 0, 1, 32'h100,      1, 0, 0, 0, 0, 32'h0));
      vecs.push_back(v(1, 0, 1, 32'h100,      1, 0, 0, 0, 0, 32'h0));
      vecs.push_back(v(1, 0, 1, 32'h100,      1, 0, 0, 0, 0, 32'h0));
      vecs.push_back(v(1, 0, 1, 32'h100,      0, 0, 1, 1, 0, 32'h100));
      vecs.push_back(v(1, 0, 0, 32'h200,      0, 0, 1, 1, 0, 32'h100));
      vecs.push_back(v(1, 0, 0, 32'h200,      0, 1, 0, 0, 0, 32'h0));
      // Flush beats a simultaneous push and pop; back-to-back flushes.
      vecs.push_back(v(1, 0, 1, 32'h300,      0, 0, 1, 1, 0, 32'h300));
      vecs.push_back(v(1, 0, 1, 32'h304,      0, 0, 2, 1, 0, 32'h300));
      vecs.push_back(v(1, 0, 1, 32'h308,      0, 0, 3, 1, 0, 32'h300));
      vecs.push_back(v(1, 1, 1, 32'h30c,      0, 1, 0, 0, 0, 32'h0));
      vecs.push_back(v(1, 0, 1, 32'h400,      0, 0, 1, 1, 0, 32'h400));
      vecs.push_back(v(1, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(v(1, 1, 1, 32'h404,      0, 1, 0, 0, 0, 32'h0));
      // Reset while full.
      vecs.push_back(v(1, 0, 1, 32'h500,      0, 0, 1, 1, 0, 32'h500));
      vecs.push_back(v(1, 0, 1, 32'h504,      0, 0, 2, 1, 0, 32'h500));
      vecs.push_back(v(1, 0, 1, 32'h508,      0, 0, 3, 1, 0, 32'h500));
      vecs.push_back(v(1, 0, 1, 32'h50c,      0, 0, 4, 1, 1, 32'h500));
      vecs.push_back(v(0, 0, 1, 32'h510,      0, 1, 0, 0, 0, 32'h0));
      vecs.push_back(v(1, 0, 1, 32'h600,      0, 0, 1, 1, 0, 32'h600));
      vecs.push_back(v(1, 0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].flush, vecs[i].valid, vecs[i].pc,
               vecs[i].stall, vecs[i].ready);
         tick();
         chk($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vecs[i].exp_count));
         chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
         chk($sformatf("v%0d_busy", i), 64'(backend_busy), 64'(vecs[i].exp_busy));
         chk($sformatf("v%0d_pc", i), 64'(out_pkt.pc), 64'(vecs[i].exp_pc));
      end

      // Steady push+pop across several pointer wraps: occupancy stays at 1 and
      // the head advances by one packet every cycle.
      drive(1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 1'b1);
      tick();
      prev_pc = 32'h700;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b1, 32'h704 + 32'(4 * i), 1'b0, 1'b1);
         tick();
         chk($sformatf("wrap%0d_count", i), 64'(fifo_count), 64'd1);
         chk($sformatf("wrap%0d_pc", i), 64'(out_pkt.pc), 64'(prev_pc + 32'd4));
         prev_pc = prev_pc + 32'd4;
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();

      // Random traffic with occasional flush and reset, checked by the scoreboard.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 2) != 0));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
